// File: rtl/sync_token_pkg.sv
// ----------------------------------------------------------------------------
// sync_token_pkg
//   Shared definitions for the clocked 4-phase token source and its
//   mirror-image clocked sink.
//   Contents:
//     DATA_W_DEF      - default width of the bundled data word
//     SYNC_STAGES_DEF - default depth of the acknowledge synchronizer
//     state_e         - handshake FSM state encoding
// ----------------------------------------------------------------------------
package sync_token_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // IDLE  : waiting for a go pulse
  // SETUP : data word stable, waiting for hold low and the pipeline empty
  // REQ   : request raised, waiting for the synchronized acknowledge
  // REL   : request released, waiting for the acknowledge to fall
  // DONE  : one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ   = 3'd2,
    REL   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage : sync_token_pkg

// File: rtl/hs_sync.sv
// ----------------------------------------------------------------------------
// hs_sync
//   Multi-flop synchronizer for a single handshake level coming from an
//   asynchronous domain (4-phase req or ack).  Shared by the token source
//   and the clocked sink.
//   Ports:
//     clk - sampling clock
//     rst - synchronous active-high reset, clears every stage
//     d   - asynchronous input level
//     q   - synchronized level, output of the last stage
//   Parameter:
//     STAGES - number of flops in the chain, 2 or 3
// ----------------------------------------------------------------------------
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: every stage is cleared on reset so a stale handshake level from
  // before reset can never appear on q after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : hs_sync

// File: rtl/sync_token_src.sv
// ----------------------------------------------------------------------------
// sync_token_src
//   Clocked source that injects a burst of tokens into an asynchronous
//   4-phase bundled-data pipeline.  Each token carries an incrementing data
//   word starting at 0.  The acknowledge is synchronized before use, so the
//   request is a clean flop output with no combinational path from la.
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous active-high reset
//     go   - start pulse, honoured only in IDLE
//     ntok - number of tokens for the burst, sampled with go
//     hold - while high, no new request is raised
//     lr   - 4-phase request to the first pipeline controller
//     la   - 4-phase acknowledge, asynchronous to clk
//     data - bundled data word accompanying lr
//     busy - high whenever the FSM is not in IDLE
//     done - one-cycle pulse at the end of a burst
//     sent - tokens completed in the current or last burst
//   Parameters:
//     DATA_W      - data word width
//     SYNC_STAGES - acknowledge synchronizer depth, 2 or 3
// ----------------------------------------------------------------------------
module sync_token_src
  import sync_token_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [7:0]        ntok,
  input  logic              hold,
  output logic              lr,
  input  logic              la,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        sent
);

  // --------------------------------------------------------------------------
  // Acknowledge synchronizer: la_s is the only view of la used below.
  // --------------------------------------------------------------------------
  logic la_s;

  hs_sync #(
    .STAGES (SYNC_STAGES)
  ) u_la_sync (
    .clk (clk),
    .rst (rst),
    .d   (la),
    .q   (la_s)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e              state_q,  state_d;
  logic                lr_q,     lr_d;
  logic [DATA_W-1:0]   data_q,   data_d;
  logic [7:0]          sent_q,   sent_d;
  logic [7:0]          target_q, target_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lr_q     <= 1'b0;
      data_q   <= '0;
      sent_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      lr_q     <= lr_d;
      data_q   <= data_d;
      sent_q   <= sent_d;
      target_q <= target_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic.  lr is set and cleared on the same edges that enter
  // REQ and REL, so it is high exactly while the FSM sits in REQ yet comes
  // straight from a flop.  data only moves on entry to SETUP, when both lr
  // and la_s are low, which preserves the bundled-data setup guarantee.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets its default first; a path that
    // skipped an assignment would otherwise infer a latch.
    state_d  = state_q;
    lr_d     = lr_q;
    data_d   = data_q;
    sent_d   = sent_q;
    target_d = target_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          sent_d = '0;
          if (ntok != 8'd0) begin
            state_d  = SETUP;
            target_d = ntok;
            data_d   = '0;
          end else begin
            // Empty burst: report completion without touching the pipeline.
            state_d = DONE;
          end
        end
      end

      SETUP: begin
        // Wait for hold low and for the pipeline to have fully released any
        // previous (or stale) acknowledge before raising a new request.
        if (!hold && !la_s) begin
          state_d = REQ;
          lr_d    = 1'b1;
        end
      end

      REQ: begin
        if (la_s) begin
          state_d = REL;
          lr_d    = 1'b0;
          sent_d  = sent_q + 8'd1;
        end
      end

      REL: begin
        if (!la_s) begin
          if (sent_q == target_q) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            data_d  = data_q + DATA_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        lr_d    = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign lr   = lr_q;
  assign data = data_q;
  assign sent = sent_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule : sync_token_src

// File: tb/tb_sync_token_src.sv
// ----------------------------------------------------------------------------
// tb_sync_token_src
//   Self-checking bench for sync_token_src.  An acknowledge agent plays the
//   asynchronous pipeline (automatic with optional random delay, or manual);
//   a monitor records every request rise with its data word and cycle
//   number and flags any data change during a handshake.  Expected values
//   come from the burst rules: token k carries k mod 2^DATA_W, a burst of n
//   yields n requests and sent == n, and back-to-back tokens with an
//   instant acknowledge are 2*SYNC_STAGES+3 cycles apart.
// ----------------------------------------------------------------------------
module tb_sync_token_src;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int PERIOD_MIN  = 2 * SYNC_STAGES + 3;
  localparam int BOUND       = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic [7:0]        ntok;
  logic              hold;
  logic              lr;
  logic              la;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic [7:0]        sent;

  int checks = 0;
  int errors = 0;

  // Acknowledge agent controls
  bit ack_auto = 1'b1;
  bit ack_rand = 1'b0;
  bit man_la   = 1'b0;

  // Monitor observations
  int rise_d[$];
  int rise_t[$];
  int viol     = 0;
  int done_cnt = 0;
  int cyc_cnt  = 0;

  sync_token_src #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .ntok (ntok),
    .hold (hold),
    .lr   (lr),
    .la   (la),
    .data (data),
    .busy (busy),
    .done (done),
    .sent (sent)
  );

  always #5 clk = ~clk;

  // Pipeline model: la follows lr after 0..3 cycles, or follows man_la.
  initial begin : ack_agent
    int wait_cnt;
    int cur_dly;
    wait_cnt = 0;
    cur_dly  = 0;
    la       = 1'b0;
    forever begin
      @(negedge clk);
      if (!ack_auto) begin
        wait_cnt = 0;
        #1 la = man_la;
      end else if (lr !== la) begin
        if (wait_cnt >= cur_dly) begin
          wait_cnt = 0;
          cur_dly  = ack_rand ? int'($urandom_range(0, 3)) : 0;
          #1 la = lr;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: samples at the falling edge; all drivers change 1 time unit later.
  initial begin : monitor
    logic              lr_p;
    logic              la_p;
    logic              in_hs;
    logic [DATA_W-1:0] d_p;
    lr_p  = 1'b0;
    la_p  = 1'b0;
    in_hs = 1'b0;
    d_p   = '0;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (rst !== 1'b0) begin
        in_hs = 1'b0;
      end else begin
        if ((lr_p === 1'b1 || (in_hs && la_p === 1'b1)) && data !== d_p) viol++;
        if (lr === 1'b1 && lr_p !== 1'b1) begin
          rise_d.push_back(int'(data));
          rise_t.push_back(cyc_cnt);
          in_hs = 1'b1;
        end
        if (lr === 1'b0 && la === 1'b0) in_hs = 1'b0;
        if (done === 1'b1) done_cnt++;
      end
      lr_p = lr;
      la_p = la;
      d_p  = data;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end want end");
    $fatal(1, "watchdog");
  end

  function automatic int exp_data(int k);
    return k % (1 << DATA_W);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    rise_d.delete();
    rise_t.delete();
    viol     = 0;
    done_cnt = 0;
  endtask

  // Index of the first request whose data word breaks the 0,1,2.. rule, or -1.
  function automatic int first_bad_seq();
    for (int i = 0; i < rise_d.size(); i++) begin
      if (rise_d[i] !== exp_data(i)) return i;
    end
    return -1;
  endfunction

  // Pulse go with ntok=n, then wait (bounded) for done.  With spam set, stray
  // go pulses with random ntok are injected while the burst runs.
  task automatic do_burst(input int n, input bit spam, output bit to);
    int c;
    clear_obs();
    go   = 1'b1;
    ntok = 8'(n);
    tick();
    go = 1'b0;
    c  = 0;
    while (done !== 1'b1 && c < BOUND) begin
      if (spam) begin
        go   = ($urandom_range(0, 3) == 0);
        ntok = 8'($urandom);
      end
      tick();
      c++;
    end
    go = 1'b0;
    to = (done !== 1'b1);
    tick();
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst  = 1'b1;
    go   = 1'b0;
    ntok = 8'd0;
    hold = 1'b0;
    tick();
    tick();
    checks++;
    if (lr !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sent !== 8'd0 || data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got lr=%b busy=%b done=%b sent=%0d data=%0h want all zero",
               lr, busy, done, sent, data);
    end
    rst = 1'b0;
    clear_obs();
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || lr !== 1'b0 || rise_d.size() != 0) begin
      errors++;
      $display("FAIL reset_stays_idle: got busy=%b lr=%b rises=%0d want 0 0 0",
               busy, lr, rise_d.size());
    end
  endtask

  task automatic test_single();
    int c;
    ack_auto = 1'b1;
    ack_rand = 1'b0;
    clear_obs();
    go   = 1'b1;
    ntok = 8'd1;
    tick();
    go = 1'b0;
    checks++;
    if (lr !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_cycle1: got lr=%b busy=%b want lr=0 busy=1", lr, busy);
    end
    tick();
    checks++;
    if (lr !== 1'b1 || data !== '0) begin
      errors++;
      $display("FAIL single_cycle2: got lr=%b data=%0h want lr=1 data=0", lr, data);
    end
    c = 0;
    while (done !== 1'b1 && c < BOUND) begin
      tick();
      c++;
    end
    checks++;
    if (done !== 1'b1 || sent !== 8'd1) begin
      errors++;
      $display("FAIL single_done: got done=%b sent=%0d want done=1 sent=1", done, sent);
    end
    tick();
    tick();
    checks++;
    if (rise_d.size() != 1 || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_counts: got rises=%0d dones=%0d busy=%b want 1 1 0",
               rise_d.size(), done_cnt, busy);
    end
  endtask

  task automatic test_burst();
    bit to;
    int bad_gap;
    ack_auto = 1'b1;
    ack_rand = 1'b0;
    do_burst(4, 1'b0, to);
    checks++;
    if (to || sent !== 8'd4 || rise_d.size() != 4) begin
      errors++;
      $display("FAIL burst4_count: got timeout=%b sent=%0d rises=%0d want 0 4 4",
               to, sent, rise_d.size());
    end
    checks++;
    if (first_bad_seq() != -1 || viol != 0) begin
      errors++;
      $display("FAIL burst4_data: got first_bad_index=%0d unstable=%0d want -1 0",
               first_bad_seq(), viol);
    end
    bad_gap = 0;
    for (int i = 1; i < rise_t.size(); i++) begin
      if (rise_t[i] - rise_t[i-1] != PERIOD_MIN) bad_gap = rise_t[i] - rise_t[i-1];
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL burst4_period: got gap %0d want %0d", bad_gap, PERIOD_MIN);
    end
    checks++;
    if (data !== DATA_W'(3) || busy !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL burst4_retain: got data=%0h busy=%b dones=%0d want 3 0 1",
               data, busy, done_cnt);
    end
  endtask

  task automatic test_zero();
    clear_obs();
    go   = 1'b1;
    ntok = 8'd0;
    tick();
    go = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || lr !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b lr=%b want 1 1 0", done, busy, lr);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sent !== 8'd0 || rise_d.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_after: got done=%b busy=%b sent=%0d rises=%0d dones=%0d want 0 0 0 0 1",
               done, busy, sent, rise_d.size(), done_cnt);
    end
  endtask

  task automatic test_hold();
    int  c;
    bit  lr_seen;
    ack_auto = 1'b1;
    ack_rand = 1'b0;
    clear_obs();
    go   = 1'b1;
    ntok = 8'd3;
    tick();
    go = 1'b0;
    c  = 0;
    while (sent !== 8'd1 && c < 200) begin
      tick();
      c++;
    end
    hold = 1'b1;
    lr_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (lr !== 1'b0) lr_seen = 1'b1;
    end
    checks++;
    if (lr_seen || busy !== 1'b1 || sent !== 8'd1) begin
      errors++;
      $display("FAIL hold_blocks: got lr_seen=%b busy=%b sent=%0d want 0 1 1",
               lr_seen, busy, sent);
    end
    hold = 1'b0;
    c    = 0;
    while (done !== 1'b1 && c < BOUND) begin
      tick();
      c++;
    end
    tick();
    checks++;
    if (sent !== 8'd3 || rise_d.size() != 3 || first_bad_seq() != -1 || viol != 0) begin
      errors++;
      $display("FAIL hold_resume: got sent=%0d rises=%0d bad=%0d unstable=%0d want 3 3 -1 0",
               sent, rise_d.size(), first_bad_seq(), viol);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    ack_auto = 1'b1;
    ack_rand = 1'b0;
    do_burst(255, 1'b0, to);
    checks++;
    if (to || sent !== 8'd255 || rise_d.size() != 255) begin
      errors++;
      $display("FAIL full_burst_count: got timeout=%b sent=%0d rises=%0d want 0 255 255",
               to, sent, rise_d.size());
    end
    checks++;
    if (first_bad_seq() != -1 || viol != 0 || data !== DATA_W'(exp_data(254))) begin
      errors++;
      $display("FAIL full_burst_data: got bad=%0d unstable=%0d last=%0h want -1 0 %0h",
               first_bad_seq(), viol, data, exp_data(254));
    end
  endtask

  task automatic test_stale_ack();
    bit to;
    bit lr_seen;
    int c;
    ack_auto = 1'b0;
    man_la   = 1'b1;
    repeat (4) tick();
    clear_obs();
    go   = 1'b1;
    ntok = 8'd3;
    tick();
    go = 1'b0;
    lr_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      go   = (i == 2);
      ntok = 8'd9;
      tick();
      if (lr !== 1'b0) lr_seen = 1'b1;
    end
    go = 1'b0;
    checks++;
    if (lr_seen || busy !== 1'b1) begin
      errors++;
      $display("FAIL stale_wait: got lr_seen=%b busy=%b want 0 1", lr_seen, busy);
    end
    man_la   = 1'b0;
    ack_auto = 1'b1;
    c = 0;
    while (done !== 1'b1 && c < BOUND) begin
      go   = ($urandom_range(0, 2) == 0);
      ntok = 8'($urandom);
      tick();
      c++;
    end
    go = 1'b0;
    to = (done !== 1'b1);
    tick();
    tick();
    checks++;
    if (to || sent !== 8'd3 || rise_d.size() != 3 || done_cnt != 1 || first_bad_seq() != -1) begin
      errors++;
      $display("FAIL stale_result: got timeout=%b sent=%0d rises=%0d dones=%0d bad=%0d want 0 3 3 1 -1",
               to, sent, rise_d.size(), done_cnt, first_bad_seq());
    end
  endtask

  task automatic test_reset_mid();
    int  c;
    bit  lr_seen;
    ack_auto = 1'b0;
    man_la   = 1'b0;
    repeat (4) tick();
    go   = 1'b1;
    ntok = 8'd5;
    tick();
    go = 1'b0;
    c  = 0;
    while (lr !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    man_la = 1'b1;
    tick();
    checks++;
    if (lr !== 1'b1 || la !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: got lr=%b la=%b want 1 1", lr, la);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (lr !== 1'b0 || busy !== 1'b0 || sent !== 8'd0 || data !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: got lr=%b busy=%b sent=%0d data=%0h want 0 0 0 0",
               lr, busy, sent, data);
    end
    rst = 1'b0;
    tick();
    clear_obs();
    go   = 1'b1;
    ntok = 8'd2;
    tick();
    go = 1'b0;
    lr_seen = 1'b0;
    repeat (6) begin
      tick();
      if (lr !== 1'b0) lr_seen = 1'b1;
    end
    checks++;
    if (lr_seen) begin
      errors++;
      $display("FAIL rstmid_wait_la: got lr raised=%b want 0", lr_seen);
    end
    man_la   = 1'b0;
    ack_auto = 1'b1;
    c = 0;
    while (done !== 1'b1 && c < BOUND) begin
      tick();
      c++;
    end
    tick();
    tick();
    checks++;
    if (sent !== 8'd2 || rise_d.size() != 2 || first_bad_seq() != -1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_rerun: got sent=%0d rises=%0d bad=%0d busy=%b want 2 2 -1 0",
               sent, rise_d.size(), first_bad_seq(), busy);
    end
  endtask

  task automatic test_random();
    bit to;
    int n;
    ack_auto = 1'b1;
    ack_rand = 1'b1;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 12));
      do_burst(n, 1'b1, to);
      checks++;
      if (to || sent !== 8'(n) || rise_d.size() != n || done_cnt != 1) begin
        errors++;
        $display("FAIL random_count[%0d]: got timeout=%b sent=%0d rises=%0d dones=%0d want 0 %0d %0d 1",
                 it, to, sent, rise_d.size(), done_cnt, n, n);
      end
      checks++;
      if (first_bad_seq() != -1 || viol != 0) begin
        errors++;
        $display("FAIL random_data[%0d]: got bad=%0d unstable=%0d want -1 0",
                 it, first_bad_seq(), viol);
      end
    end
    ack_rand = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_zero();
    test_hold();
    test_back_to_back();
    test_stale_ack();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_token_src
